// File: rtl/dpi_stream_sequencer_if.sv
// Ingress packet byte stream shared by the packet source and the sequencer.
//   pkt_data      : byte
//   pkt_vld       : beat valid
//   pkt_sop/eop   : first/last byte of a packet (qualified by pkt_vld)
//   pkt_stream_id : stream id, meaningful on the sop beat
//   pkt_rdy       : beat consumed when pkt_vld & pkt_rdy
interface dpi_stream_sequencer_if;
  logic [7:0] pkt_data;
  logic       pkt_vld;
  logic       pkt_sop;
  logic       pkt_eop;
  logic [5:0] pkt_stream_id;
  logic       pkt_rdy;

  modport master (output pkt_data, pkt_vld, pkt_sop, pkt_eop, pkt_stream_id,
                  input  pkt_rdy);
  modport slave  (input  pkt_data, pkt_vld, pkt_sop, pkt_eop, pkt_stream_id,
                  output pkt_rdy);
endinterface

// File: rtl/dpi_stream_sequencer.sv
// Feeds one packet at a time into the bank of regex matcher wrappers:
// restore DFA state (load_state), stream bytes, let the matcher pipeline
// drain, then commit (eop). Owns the per-stream seen bitmap and the
// per-stream regex enable table.
//   clk, rst_n      : clock, async active-low reset
//   pkt             : ingress byte stream (slave side)
//   cfg_*           : enable-table write port, seen-bitmap clear
//   char_out(_vld)  : byte to matchers, combinational from pkt in STREAM
//   load_state, eop : one-cycle restore / commit strobes
//   stream_id, enable, new_stream_id : per-packet context for the matchers
//   busy, pkt_cnt, proto_err         : status
module dpi_stream_sequencer #(
  parameter int NUM_REGEX = 8,
  parameter int LOAD_GAP  = 2,   // 2..7
  parameter int DRAIN_LAT = 3    // 3..7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dpi_stream_sequencer_if.slave pkt,
  input  logic                 cfg_wr,
  input  logic [5:0]           cfg_stream_id,
  input  logic [NUM_REGEX-1:0] cfg_en_mask,
  input  logic                 cfg_clear_seen,
  output logic [7:0]           char_out,
  output logic                 char_out_vld,
  output logic                 load_state,
  output logic                 eop,
  output logic [5:0]           stream_id,
  output logic                 new_stream_id,
  output logic [NUM_REGEX-1:0] enable,
  output logic                 busy,
  output logic [15:0]          pkt_cnt,
  output logic                 proto_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_GAP, S_STREAM, S_DRAIN, S_EOP
  } state_t;

  state_t                          state;
  logic [2:0]                      cnt;
  logic                            first;   // next accepted beat is the sop beat
  logic [63:0]                     seen;
  logic [63:0][NUM_REGEX-1:0]      en_tbl;
  logic                            rdy;
  logic                            in_stream;

  assign in_stream    = (state == S_STREAM);
  assign busy         = (state != S_IDLE);
  assign char_out     = in_stream ? pkt.pkt_data : 8'd0;
  assign char_out_vld = in_stream & pkt.pkt_vld;
  assign pkt.pkt_rdy  = rdy;

  // In IDLE a sop beat is held (not consumed) until STREAM so it becomes the
  // first byte; a stray non-sop beat is swallowed to keep the source moving.
  always_comb begin
    rdy = 1'b0;
    case (state)
      S_IDLE:   rdy = pkt.pkt_vld & ~pkt.pkt_sop;
      S_STREAM: rdy = 1'b1;
      default:  rdy = 1'b0;
    endcase
  end

  // Counters are loaded with N-1 so exactly N idle cycles elapse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      first         <= 1'b0;
      load_state    <= 1'b0;
      eop           <= 1'b0;
      stream_id     <= '0;
      new_stream_id <= 1'b0;
      enable        <= '0;
      pkt_cnt       <= '0;
      proto_err     <= 1'b0;
    end else begin
      load_state    <= 1'b0;
      eop           <= 1'b0;
      new_stream_id <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pkt.pkt_vld && pkt.pkt_sop) begin
            stream_id     <= pkt.pkt_stream_id;
            enable        <= en_tbl[pkt.pkt_stream_id];
            new_stream_id <= ~seen[pkt.pkt_stream_id];
            load_state    <= 1'b1;
            state         <= S_LOAD;
          end else if (pkt.pkt_vld) begin
            proto_err <= 1'b1;
          end
        end
        S_LOAD: begin
          cnt   <= 3'(LOAD_GAP - 1);
          first <= 1'b1;
          state <= S_GAP;
        end
        S_GAP: begin
          if (cnt == 3'd0) state <= S_STREAM;
          else             cnt   <= cnt - 3'd1;
        end
        S_STREAM: begin
          if (pkt.pkt_vld) begin
            first <= 1'b0;
            if (pkt.pkt_sop && !first) proto_err <= 1'b1;
            if (pkt.pkt_eop) begin
              cnt   <= 3'(DRAIN_LAT - 1);
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (cnt == 3'd0) begin
            eop   <= 1'b1;
            state <= S_EOP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_EOP: begin
          pkt_cnt <= pkt_cnt + 16'd1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Seen bitmap: the commit set is ordered after the clear so it wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen <= '0;
    end else begin
      if (cfg_clear_seen)    seen            <= '0;
      if (state == S_EOP)    seen[stream_id] <= 1'b1;
    end
  end

  // Enable table; the active packet keeps its own copy in `enable`.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      en_tbl                <= '0;
    else if (cfg_wr) en_tbl[cfg_stream_id] <= cfg_en_mask;
  end

endmodule
